// File: rtl/ram_2ch_arbitrated_if.sv
// Two-requester memory bus: level req held until a one-cycle ack.
// Master drives requests; slave (the RAM) returns ack and read data.
interface ram_2ch_arbitrated_if #(
  parameter int width = 8,
  parameter int depth = 16
);
  logic             i_a_req;
  logic             i_a_write;
  logic [depth-1:0] i_a_addr;
  logic [width-1:0] i_a_data;
  logic             o_a_ack;
  logic [width-1:0] o_a_data;
  logic             i_b_req;
  logic             i_b_write;
  logic [depth-1:0] i_b_addr;
  logic [width-1:0] i_b_data;
  logic             o_b_ack;
  logic [width-1:0] o_b_data;

  modport master (
    output i_a_req, i_a_write, i_a_addr, i_a_data,
    output i_b_req, i_b_write, i_b_addr, i_b_data,
    input  o_a_ack, o_a_data, o_b_ack, o_b_data
  );

  modport slave (
    input  i_a_req, i_a_write, i_a_addr, i_a_data,
    input  i_b_req, i_b_write, i_b_addr, i_b_data,
    output o_a_ack, o_a_data, o_b_ack, o_b_data
  );
endinterface

// File: rtl/ram_2ch_arbitrated.sv
// Single-port RAM shared by two channels via a round-robin arbiter.
// One access per cycle; completion is acked after a fixed pipeline latency.
module ram_2ch_arbitrated #(
  parameter int width   = 8,
  parameter int depth   = 16,
  parameter int latency = 1
) (
  input  logic                 clk,
  input  logic                 rst_x,
  ram_2ch_arbitrated_if.slave  bus
);

  if (latency < 1 || latency > 4) begin : g_bad_latency
    initial begin
      $display("ram_2ch_arbitrated: illegal latency %0d", latency);
      $finish;
    end
  end

  logic [width-1:0] r_mem [2**depth];

  logic             r_busy_a;
  logic             r_busy_b;
  logic             r_ptr;
  logic [latency:1] r_vld;
  logic [latency:1] r_ch;
  logic [latency:1] r_wr;
  logic [width-1:0] r_dat [1:latency];
  logic [width-1:0] r_a_hold;
  logic [width-1:0] r_b_hold;

  logic             w_el_a;
  logic             w_el_b;
  logic             w_gnt_a;
  logic             w_gnt_b;
  logic             w_gnt;
  logic             w_wr;
  logic [depth-1:0] w_addr;
  logic [width-1:0] w_wdat;
  logic [width-1:0] w_rdat;
  logic             w_ack_a;
  logic             w_ack_b;
  logic             w_rd_out;

  assign w_el_a  = bus.i_a_req & ~r_busy_a;
  assign w_el_b  = bus.i_b_req & ~r_busy_b;
  // r_ptr = 0 favours A, 1 favours B; only consulted on contention
  assign w_gnt_a = w_el_a & (~w_el_b | ~r_ptr);
  assign w_gnt_b = w_el_b & (~w_el_a | r_ptr);
  assign w_gnt   = w_gnt_a | w_gnt_b;

  assign w_wr   = w_gnt_b ? bus.i_b_write : bus.i_a_write;
  assign w_addr = w_gnt_b ? bus.i_b_addr  : bus.i_a_addr;
  assign w_wdat = w_gnt_b ? bus.i_b_data  : bus.i_a_data;
  assign w_rdat = r_mem[w_addr];

  always_ff @(posedge clk) begin
    if (w_gnt & w_wr) begin
      r_mem[w_addr] <= w_wdat;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_busy_a <= 1'b0;
      r_busy_b <= 1'b0;
      r_ptr    <= 1'b0;
      r_vld    <= '0;
      r_ch     <= '0;
      r_wr     <= '0;
      r_a_hold <= '0;
      r_b_hold <= '0;
      for (int i = 1; i <= latency; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[1] <= w_gnt;
      r_ch[1]  <= w_gnt_b;
      r_wr[1]  <= w_wr;
      r_dat[1] <= w_rdat;
      for (int i = 2; i <= latency; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_ch[i]  <= r_ch[i-1];
        r_wr[i]  <= r_wr[i-1];
        r_dat[i] <= r_dat[i-1];
      end
      if (w_el_a & w_el_b) begin
        r_ptr <= ~r_ptr;
      end
      if (w_gnt_a) begin
        r_busy_a <= 1'b1;
      end else if (w_ack_a) begin
        r_busy_a <= 1'b0;
      end
      if (w_gnt_b) begin
        r_busy_b <= 1'b1;
      end else if (w_ack_b) begin
        r_busy_b <= 1'b0;
      end
      if (w_ack_a & w_rd_out) begin
        r_a_hold <= r_dat[latency];
      end
      if (w_ack_b & w_rd_out) begin
        r_b_hold <= r_dat[latency];
      end
    end
  end

  assign w_ack_a  = r_vld[latency] & ~r_ch[latency];
  assign w_ack_b  = r_vld[latency] & r_ch[latency];
  assign w_rd_out = ~r_wr[latency];

  // read data is live in the ack cycle, then the hold register keeps it
  assign bus.o_a_ack  = w_ack_a;
  assign bus.o_b_ack  = w_ack_b;
  assign bus.o_a_data = (w_ack_a & w_rd_out) ? r_dat[latency] : r_a_hold;
  assign bus.o_b_data = (w_ack_b & w_rd_out) ? r_dat[latency] : r_b_hold;

endmodule

// File: doc/ram_2ch_arbitrated.md
Name: ram_2ch_arbitrated

Overview:
- Parametrised clocked successor to the asynchronous simulation RAM models.
- Holds one single-port array of 2^depth words of width bits, shared by two requester channels (A, B).
- A round-robin arbiter grants one access per cycle; reads return after a configurable pipeline latency.
- Used where two bus masters (e.g. CPU and video fetch) share one memory.

Parameters:
- width, 8, data word width in bits (1..64)
- depth, 16, address width in bits; array holds 2^depth words
- latency, 1, cycles from grant edge to ack/data (1..4)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_x  input  1  asynchronous reset, active low
- i_a_req  input  1  channel A request, level, held until o_a_ack
- i_a_write  input  1  channel A: 1 = write, 0 = read
- i_a_addr  input  depth  channel A word address
- i_a_data  input  width  channel A write data
- o_a_ack  output  1  channel A one-cycle completion pulse
- o_a_data  output  width  channel A read data, valid with o_a_ack on reads
- i_b_req, i_b_write, i_b_addr, i_b_data, o_b_ack, o_b_data: same as channel A, for channel B

Behaviour:
- Reset is asynchronous and active low on rst_x:
  - o_a_ack, o_b_ack = 0; o_a_data, o_b_data = 0.
  - Pipeline valid bits cleared; both channels idle (not busy); round-robin pointer = A.
  - Array contents are not reset. Reads of never-written words return X in simulation.
- Eligibility: a channel is eligible in a cycle when its req = 1 and it is not busy.
  - Busy means granted, with ack not yet issued.
  - A channel has at most one access outstanding.
- Arbitration, evaluated every cycle:
  - Neither eligible: no grant.
  - Exactly one eligible: grant that channel.
  - Both eligible: grant the channel named by the pointer, then set the pointer to the other channel.
  - The pointer changes only on a contended grant.
- Grant cycle n: addr, write and data of the granted channel are sampled at the rising edge ending cycle n. The channel becomes busy.
- Writes commit to the array at that same edge.
- Reads sample the array at that edge, after any write committing at the same edge has been excluded. Only one access happens per edge, so read/write collision is impossible.
- Completion: ack pulses high for exactly one cycle, in cycle n+latency.
  - For reads, o_x_data carries the word in the ack cycle.
  - o_x_data holds its last read value at all other times. Writes do not change o_x_data.
  - Busy clears at the end of the ack cycle.
- Back-to-back: if req is still high during the ack cycle, it is a new request.
  - It is eligible in cycle n+latency+1, and is not granted in the ack cycle itself.
  - A requester wanting a single access drops req in the ack cycle.
- Throughput:
  - The array performs at most one access per cycle.
  - Per channel, at most one access per latency+1 cycles.
  - With both channels streaming and latency = 1, accesses alternate A, B, A, B with zero idle array cycles.
- Ordering: an access granted in cycle n observes every write granted in cycles < n, from either channel.
- Requester rules:
  - addr, write and data must be stable from req rise until the ack cycle.
  - Changes while busy are ignored.
  - Dropping req while busy does not cancel the access; the ack is still issued.
- Reset mid-operation: all in-flight accesses are discarded and no ack is issued. A write sampled before reset remains in the array.
- Address wrap: none. The addr width exactly spans the array.
- Illegal latency values (0, or >4) are a static configuration error. Flag with an elaboration-time $display and $finish.

Test Plan:
- Reset, then A writes 0x5A at 0x1234 → o_a_ack high in cycle n+1 only. A then reads 0x1234 → o_a_ack with o_a_data = 0x5A; o_b_ack stays 0.
- A and B both request in the same cycle after reset → A granted first, B granted the next cycle. The next contended cycle grants B first.
- latency = 3:
  - B reads 0x0010 (contains 0xC3) → o_b_ack exactly 3 cycles after grant, o_b_data = 0xC3.
  - A read at 0x0020 (contains 0x7E) granted the following cycle → acked one cycle later than B, o_a_data = 0x7E.
- Write/read ordering:
  - A writes 0xFF to 0x0001 while B reads 0x0001 in the next grant slot → B returns 0xFF.
  - With B granted first instead, B returns the old value 0x00.
- Both channels stream 16 accesses with req held high, latency = 1 → 32 acks in 32 + 1 cycles, alternating A/B; all read data matches a scoreboard.
- Reset asserted while a read is in its latency pipeline → no ack after reset release; outputs 0; an earlier-written word reads back intact.
